// File: rtl/execute_mdu_stage.sv
// execute_mdu_stage: EX stage with a single-cycle integer ALU, an iterative
// RV32M/RV64M multiply/divide unit, operand forwarding and the EX/MEM register.
// Optional macro EXECUTE_MDU_FAST_MUL_EN: multiplies use a combinational
// multiplier and complete in one cycle like ALU ops; divides stay iterative.
module execute_mdu_stage #(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_md,
  input  logic [3:0]      alu_op,
  input  logic [2:0]      md_op,
  input  logic            a_is_reg,
  input  logic            b_is_reg,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            reg_write,
  input  logic            ex_fwd_wr,
  input  logic            mem_fwd_wr,
  input  logic [4:0]      ex_fwd_rd,
  input  logic [4:0]      mem_fwd_rd,
  input  logic [XLEN-1:0] ex_fwd_data,
  input  logic [XLEN-1:0] mem_fwd_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            busy
);

  localparam int SHW   = $clog2(XLEN);
  localparam int N_MUL = XLEN / MUL_BPC;
  localparam int CW    = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   MUL_LAST = CW'(N_MUL - 1);
  localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] XZERO    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] XONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3} state_t;

  // Two's-complement negate when requested
  function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (XZERO - v) : v;
  endfunction

  state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, mag_b_q, mag_b_d, a_q, a_d, b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      md_rd_q, md_rd_d;
  logic            md_wr_q, md_wr_d, a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic            out_valid_q, out_valid_d, out_rw_q, out_rw_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic [4:0]      out_rd_q, out_rd_d;

  logic [XLEN-1:0] op_a_s, op_b_s, alu_s, single_res_s, md_res_s, prod_hi_s, prod_lo_s;
  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN:0] mul_t_s;
  logic [XLEN:0]   div_r_s;
  logic            div_bit_s, accept_s, fast_s, alu_accept_s, md_start_s;
  logic            sa_s, sb_s, a_neg_s, b_neg_s, dz_s, ovf_s, md_special_s, dzq_s, ovq_s;
  logic [SHW-1:0]  shamt_s;

  // Operand forwarding: EX/MEM source has priority over MEM/WB, x0 never forwards
  always_comb begin
    op_a_s = opa;
    op_b_s = opb;
    if (a_is_reg && ex_fwd_wr && (ex_fwd_rd != 5'd0) && (ex_fwd_rd == rs1)) op_a_s = ex_fwd_data;
    else if (a_is_reg && mem_fwd_wr && (mem_fwd_rd != 5'd0) && (mem_fwd_rd == rs1)) op_a_s = mem_fwd_data;
    else op_a_s = opa;
    if (b_is_reg && ex_fwd_wr && (ex_fwd_rd != 5'd0) && (ex_fwd_rd == rs2)) op_b_s = ex_fwd_data;
    else if (b_is_reg && mem_fwd_wr && (mem_fwd_rd != 5'd0) && (mem_fwd_rd == rs2)) op_b_s = mem_fwd_data;
    else op_b_s = opb;
  end

  // Single-cycle integer ALU, encoded as {funct7[5], funct3}
  always_comb begin
    alu_s   = XZERO;
    shamt_s = op_b_s[SHW-1:0];
    case (alu_op)
      4'b0000: alu_s = op_a_s + op_b_s;
      4'b1000: alu_s = op_a_s - op_b_s;
      4'b0001: alu_s = op_a_s << shamt_s;
      4'b0010: alu_s = {{(XLEN-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
      4'b0011: alu_s = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
      4'b0100: alu_s = op_a_s ^ op_b_s;
      4'b0101: alu_s = op_a_s >> shamt_s;
      4'b1101: alu_s = $unsigned($signed(op_a_s) >>> shamt_s);
      4'b0110: alu_s = op_a_s | op_b_s;
      4'b0111: alu_s = op_a_s & op_b_s;
      4'b1111: alu_s = op_b_s;
      default: alu_s = XZERO;
    endcase
  end

  // Operand signedness, magnitudes and divide special cases for the M op being accepted
  always_comb begin
    sa_s         = md_op[2] ? ~md_op[0] : (md_op[1:0] != 2'b11);
    sb_s         = md_op[2] ? ~md_op[0] : ~md_op[1];
    a_neg_s      = sa_s & op_a_s[XLEN-1];
    b_neg_s      = sb_s & op_b_s[XLEN-1];
    dz_s         = (op_b_s == XZERO);
    ovf_s        = ~md_op[0] & (op_a_s == XMIN) & (op_b_s == XONES);
    md_special_s = md_op[2] & (dz_s | ovf_s);
  end

`ifdef EXECUTE_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fm_a_s, fm_b_s, fm_p_s;
  logic [XLEN-1:0]   fast_res_s;

  // Combinational full-width multiply; ALU or multiply result for single-cycle completion
  always_comb begin
    fm_a_s       = {{XLEN{a_neg_s}}, op_a_s};
    fm_b_s       = {{XLEN{b_neg_s}}, op_b_s};
    fm_p_s       = fm_a_s * fm_b_s;
    fast_res_s   = (md_op[1:0] == 2'b00) ? fm_p_s[XLEN-1:0] : fm_p_s[2*XLEN-1:XLEN];
    fast_s       = is_md & ~md_op[2];
    single_res_s = is_md ? fast_res_s : alu_s;
  end
`else
  assign fast_s       = 1'b0;
  assign single_res_s = alu_s;
`endif

  assign accept_s     = in_valid & in_ready & ~flush;
  assign alu_accept_s = accept_s & (~is_md | fast_s);
  assign md_start_s   = accept_s & is_md & ~fast_s;

  // MDU state register, reset to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // MDU next state: flush always returns to IDLE, special divides skip straight to FIX
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (md_start_s) begin
            if (md_special_s)  state_d = S_FIX;
            else if (md_op[2]) state_d = S_DIV;
            else               state_d = S_MUL;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL:   state_d = (cnt_q == CNT_ZERO) ? S_FIX : S_MUL;
        S_DIV:   state_d = (cnt_q == CNT_ZERO) ? S_FIX : S_DIV;
        S_FIX:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // MDU status outputs decoded from the state register
  always_comb begin
    in_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
  end

  // MDU datapath: latch operands on start, then shift-add or restoring-divide steps
  always_comb begin
    cnt_d = cnt_q;  hi_d = hi_q;  lo_d = lo_q;  mag_b_d = mag_b_q;
    a_d = a_q;  b_d = b_q;  op_d = op_q;  md_rd_d = md_rd_q;  md_wr_d = md_wr_q;
    a_neg_d = a_neg_q;  b_neg_d = b_neg_q;
    mul_t_s   = {1'b0, hi_q, lo_q};
    div_r_s   = {hi_q, lo_q[XLEN-1]};
    div_bit_s = 1'b0;
    if (md_start_s) begin
      cnt_d   = md_op[2] ? DIV_LAST : MUL_LAST;
      hi_d    = XZERO;
      lo_d    = cond_neg(a_neg_s, op_a_s);
      mag_b_d = cond_neg(b_neg_s, op_b_s);
      a_d = op_a_s;  b_d = op_b_s;  op_d = md_op;  md_rd_d = rd;  md_wr_d = reg_write;
      a_neg_d = a_neg_s;  b_neg_d = b_neg_s;
    end else if (state_q == S_MUL) begin
      for (int k = 0; k < MUL_BPC; k++) begin
        if (mul_t_s[0]) mul_t_s[2*XLEN:XLEN] = {1'b0, mul_t_s[2*XLEN-1:XLEN]} + {1'b0, mag_b_q};
        else            mul_t_s[2*XLEN:XLEN] = {1'b0, mul_t_s[2*XLEN-1:XLEN]};
        mul_t_s = mul_t_s >> 1;
      end
      hi_d  = mul_t_s[2*XLEN-1:XLEN];
      lo_d  = mul_t_s[XLEN-1:0];
      cnt_d = cnt_q - CNT_ONE;
    end else if (state_q == S_DIV) begin
      if (div_r_s >= {1'b0, mag_b_q}) begin
        div_r_s   = div_r_s - {1'b0, mag_b_q};
        div_bit_s = 1'b1;
      end else begin
        div_bit_s = 1'b0;
      end
      hi_d  = div_r_s[XLEN-1:0];
      lo_d  = {lo_q[XLEN-2:0], div_bit_s};
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // FIX result: restore signs and select product half, quotient or remainder
  always_comb begin
    prod_s = {hi_q, lo_q};
    if (a_neg_q ^ b_neg_q) prod_s = {XZERO, XZERO} - {hi_q, lo_q};
    else                   prod_s = {hi_q, lo_q};
    prod_hi_s = prod_s[2*XLEN-1:XLEN];
    prod_lo_s = prod_s[XLEN-1:0];
    dzq_s     = (b_q == XZERO);
    ovq_s     = ~op_q[0] & (a_q == XMIN) & (b_q == XONES);
    case (op_q)
      3'b000:                 md_res_s = prod_lo_s;
      3'b001, 3'b010, 3'b011: md_res_s = prod_hi_s;
      3'b100, 3'b101: begin
        if (dzq_s)      md_res_s = XONES;
        else if (ovq_s) md_res_s = a_q;
        else            md_res_s = cond_neg(a_neg_q ^ b_neg_q, lo_q);
      end
      3'b110, 3'b111: begin
        if (dzq_s)      md_res_s = a_q;
        else if (ovq_s) md_res_s = XZERO;
        else            md_res_s = cond_neg(a_neg_q, hi_q);
      end
      default:                md_res_s = XZERO;
    endcase
  end

  // EX/MEM slot: MDU completion, single-cycle op, or a bubble that holds result/rd
  always_comb begin
    out_valid_d  = 1'b0;
    out_rw_d     = 1'b0;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (state_q == S_FIX) begin
      out_valid_d  = 1'b1;
      out_rw_d     = md_wr_q;
      out_result_d = md_res_s;
      out_rd_d     = md_rd_q;
    end else if (alu_accept_s) begin
      out_valid_d  = 1'b1;
      out_rw_d     = reg_write;
      out_result_d = single_res_s;
      out_rd_d     = rd;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_ZERO;  hi_q <= XZERO;  lo_q <= XZERO;  mag_b_q <= XZERO;
      a_q <= XZERO;  b_q <= XZERO;  op_q <= 3'd0;  md_rd_q <= 5'd0;  md_wr_q <= 1'b0;
      a_neg_q <= 1'b0;  b_neg_q <= 1'b0;
      out_valid_q <= 1'b0;  out_rw_q <= 1'b0;  out_result_q <= XZERO;  out_rd_q <= 5'd0;
    end else begin
      cnt_q <= cnt_d;  hi_q <= hi_d;  lo_q <= lo_d;  mag_b_q <= mag_b_d;
      a_q <= a_d;  b_q <= b_d;  op_q <= op_d;  md_rd_q <= md_rd_d;  md_wr_q <= md_wr_d;
      a_neg_q <= a_neg_d;  b_neg_q <= b_neg_d;
      out_valid_q <= out_valid_d;  out_rw_q <= out_rw_d;
      out_result_q <= out_result_d;  out_rd_q <= out_rd_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_rd        = out_rd_q;
  assign out_reg_write = out_rw_q;

endmodule

// File: tb/tb_execute_mdu_stage.sv
// Directed self-checking bench for execute_mdu_stage (XLEN=32, MUL_BPC=1).
module tb_execute_mdu_stage;

  localparam int XLEN = 32;
`ifdef EXECUTE_MDU_FAST_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 34;
`endif

  logic            clk, rst, flush, in_valid, in_ready, is_md, a_is_reg, b_is_reg;
  logic [3:0]      alu_op;
  logic [2:0]      md_op;
  logic [4:0]      rs1, rs2, rd, ex_fwd_rd, mem_fwd_rd, out_rd;
  logic [XLEN-1:0] opa, opb, ex_fwd_data, mem_fwd_data, out_result;
  logic            reg_write, ex_fwd_wr, mem_fwd_wr, out_valid, out_reg_write, busy;

  int errors = 0;
  int checks = 0;

  execute_mdu_stage #(.XLEN(XLEN), .MUL_BPC(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .is_md(is_md), .alu_op(alu_op), .md_op(md_op), .a_is_reg(a_is_reg), .b_is_reg(b_is_reg),
    .rs1(rs1), .rs2(rs2), .rd(rd), .opa(opa), .opb(opb), .reg_write(reg_write),
    .ex_fwd_wr(ex_fwd_wr), .mem_fwd_wr(mem_fwd_wr), .ex_fwd_rd(ex_fwd_rd), .mem_fwd_rd(mem_fwd_rd),
    .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data), .out_valid(out_valid),
    .out_result(out_result), .out_rd(out_rd), .out_reg_write(out_reg_write), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [3:0] op, input logic a_reg, input logic b_reg,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic [31:0] a, input logic [31:0] b, input logic wr);
    is_md = 1'b0; alu_op = op; a_is_reg = a_reg; b_is_reg = b_reg; rs1 = r1; rs2 = r2;
    opa = a; opb = b; reg_write = wr; rd = 5'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic md_run(input string tag, input logic [2:0] op, input logic a_reg,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int n;
    int low;
    is_md = 1'b1; md_op = op; a_is_reg = a_reg; b_is_reg = 1'b0; rs1 = 5'd3; rs2 = 5'd0;
    opa = a; opb = b; rd = 5'd12; reg_write = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; is_md = 1'b0; a_is_reg = 1'b0;
    opa = 32'hDEADBEEF; opb = 32'h0BADF00D; ex_fwd_data = 32'h55555555;
    n = 1; low = 0;
    while (!out_valid && n < 200) begin
      if (!in_ready) low++;
      tick();
      n++;
    end
    check({tag, "_res"}, out_result, exp);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_stall"}, low, exp_lat - 1);
    check({tag, "_rd"}, out_rd, 5'd12);
    check({tag, "_rw"}, out_reg_write, 1'b1);
    check({tag, "_rdy"}, in_ready, 1'b1);
  endtask

  logic [3:0]  t_op [10] = '{4'b0010, 4'b0011, 4'b1101, 4'b0101, 4'b0001,
                              4'b0100, 4'b0110, 4'b0111, 4'b1111, 4'b1000};
  logic [31:0] t_a  [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h00000001,
                              32'hF0F0F0F0, 32'hF0F00000, 32'hF0F0F0F0, 32'h00000123, 32'h00000005};
  logic [31:0] t_b  [10] = '{32'h00000001, 32'h00000001, 32'h00000024, 32'h00000004, 32'h00000021,
                              32'h0FF00FF0, 32'h0000F0F0, 32'h0FF00FF0, 32'hABCDE000, 32'h00000007};
  logic [31:0] t_e  [10] = '{32'h00000001, 32'h00000000, 32'hF8000000, 32'h08000000, 32'h00000002,
                              32'hFF00FF00, 32'hF0F0F0F0, 32'h00F000F0, 32'hABCDE000, 32'hFFFFFFFE};

  initial begin
    int seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; is_md = 1'b0; alu_op = 4'd0; md_op = 3'd0;
    a_is_reg = 1'b0; b_is_reg = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; opa = 32'd0; opb = 32'd0;
    reg_write = 1'b0; ex_fwd_wr = 1'b0; mem_fwd_wr = 1'b0; ex_fwd_rd = 5'd0; mem_fwd_rd = 5'd0;
    ex_fwd_data = 32'd0; mem_fwd_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_rw", out_reg_write, 1'b0);
    check("rst_result", out_result, 32'd0);
    check("rst_rd", out_rd, 5'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    rst = 1'b0;
    tick();

    // EX forward wins over MEM forward
    ex_fwd_wr = 1'b1; ex_fwd_rd = 5'd5; ex_fwd_data = 32'd10;
    mem_fwd_wr = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'd99;
    alu(4'b0000, 1'b1, 1'b0, 5'd5, 5'd0, 32'd1234, 32'd3, 1'b1);
    check("fwd_ex_res", out_result, 32'd13);
    check("fwd_ex_valid", out_valid, 1'b1);
    check("fwd_ex_rd", out_rd, 5'd9);
    check("fwd_ex_rw", out_reg_write, 1'b1);
    ex_fwd_wr = 1'b0;
    alu(4'b0000, 1'b1, 1'b0, 5'd5, 5'd0, 32'd1234, 32'd3, 1'b1);
    check("fwd_mem_a", out_result, 32'd102);
    alu(4'b1000, 1'b0, 1'b1, 5'd0, 5'd5, 32'd1, 32'd555, 1'b1);
    check("fwd_mem_b", out_result, 32'hFFFFFF9E);
    alu(4'b0000, 1'b0, 1'b0, 5'd5, 5'd0, 32'd40, 32'd2, 1'b1);
    check("fwd_not_reg", out_result, 32'd42);

    // x0 is never forwarded
    ex_fwd_wr = 1'b1; ex_fwd_rd = 5'd0; ex_fwd_data = 32'd7; mem_fwd_wr = 1'b0;
    alu(4'b0000, 1'b1, 1'b0, 5'd0, 5'd0, 32'd0, 32'd5, 1'b1);
    check("fwd_x0", out_result, 32'd5);
    ex_fwd_wr = 1'b0;
    tick();
    check("bubble_valid", out_valid, 1'b0);
    check("bubble_rw", out_reg_write, 1'b0);
    check("bubble_hold", out_result, 32'd5);

    for (int i = 0; i < 10; i++) begin
      alu(t_op[i], 1'b0, 1'b0, 5'd0, 5'd0, t_a[i], t_b[i], 1'b1);
      check($sformatf("alu_%0d", i), out_result, t_e[i]);
    end
    alu(4'b0000, 1'b0, 1'b0, 5'd0, 5'd0, 32'd1, 32'd1, 1'b0);
    check("nowr_valid", out_valid, 1'b1);
    check("nowr_rw", out_reg_write, 1'b0);
    flush = 1'b1;
    alu(4'b0000, 1'b0, 1'b0, 5'd0, 5'd0, 32'd50, 32'd50, 1'b1);
    flush = 1'b0;
    check("flush_alu_valid", out_valid, 1'b0);
    check("flush_alu_hold", out_result, 32'd2);

    // Multiplies; first one takes A from the EX forward, which changes after accept
    ex_fwd_wr = 1'b1; ex_fwd_rd = 5'd3; ex_fwd_data = 32'd7;
    md_run("mul", 3'b000, 1'b1, 32'd0, 32'hFFFFFFFD, 32'hFFFFFFEB, MLAT);
    ex_fwd_wr = 1'b0;
    tick();
    check("mul_pulse", out_valid, 1'b0);
    md_run("mulh", 3'b001, 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, MLAT);
    md_run("mulhsu", 3'b010, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MLAT);
    md_run("mul_lo", 3'b000, 1'b0, 32'h12345678, 32'h10, 32'h23456780, MLAT);

    // Divides, including the special cases
    md_run("div_z", 3'b100, 1'b0, 32'd100, 32'd0, 32'hFFFFFFFF, 2);
    md_run("rem_z", 3'b110, 1'b0, 32'd100, 32'd0, 32'd100, 2);
    md_run("div_ovf", 3'b100, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    md_run("rem_ovf", 3'b110, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 2);
    md_run("div_neg", 3'b100, 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    md_run("rem_neg", 3'b110, 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    md_run("divu", 3'b101, 1'b0, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 34);
    md_run("remu", 3'b111, 1'b0, 32'hFFFFFFFF, 32'd16, 32'd15, 34);
    md_run("divu_big", 3'b101, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 34);
    md_run("remu_big", 3'b111, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);
    md_run("divu_z", 3'b101, 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 2);

    // MULHU then a back-to-back ALU op in the cycle after completion
    md_run("mulhu", 3'b011, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MLAT);
    alu(4'b0000, 1'b0, 1'b0, 5'd0, 5'd0, 32'd20, 32'd22, 1'b1);
    check("b2b_valid", out_valid, 1'b1);
    check("b2b_res", out_result, 32'd42);

    // Flush at edge 10 of a divide
    is_md = 1'b1; md_op = 3'b100; opa = 32'd1000; opb = 32'd3; rd = 5'd12; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; is_md = 1'b0;
    repeat (8) tick();
    check("flush_div_busy", busy, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_div_valid", out_valid, 1'b0);
    check("flush_div_busy0", busy, 1'b0);
    check("flush_div_ready", in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("flush_div_quiet", seen, 0);

    // Flush during FIX suppresses the result
    is_md = 1'b1; md_op = 3'b100; opa = 32'd5; opb = 32'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; is_md = 1'b0;
    check("fix_busy", busy, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_fix_valid", out_valid, 1'b0);
    check("flush_fix_ready", in_ready, 1'b1);

    // Async reset in the middle of a multiply
    is_md = 1'b1; md_op = 3'b000; opa = 32'd3; opb = 32'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; is_md = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_ready", in_ready, 1'b1);
    check("arst_result", out_result, 32'd0);
    check("arst_valid", out_valid, 1'b0);
    #2 rst = 1'b0;
    tick();
    alu(4'b0000, 1'b0, 1'b0, 5'd0, 5'd0, 32'd3, 32'd4, 1'b1);
    check("post_rst_alu", out_result, 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
